// File: rtl/wfg_pkg.sv
// Shared types and constants for the waveform generator host-reporting path.
// Used by the UART TX arbiter and the register decoder.
package wfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_FETCH,
        S_SEND
    } state_t;

    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

    // Command codes understood by the register decoder
    localparam logic [7:0] P_CMD_RD   = 8'h01;
    localparam logic [7:0] P_CMD_WR   = 8'h02;
    localparam logic [7:0] P_CMD_STAT = 8'h03;

    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] idx);
        return base | {5'b00000, idx};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan farthest-to-nearest so the nearest asserted request wins last
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                onehot                      = '0;
                onehot[(int'(ptr) + i) % N] = 1'b1;
                idx                         = W'((int'(ptr) + i) % N);
                any                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter sharing one UART TX; each frame starts with a source-ID header byte.
// Latency: first tx_wr_o two cycles after a request is sampled idle; one idle cycle between frames.
// Backpressure: one byte in flight; owner sees ready only after tx_done_i; stalls abort after TIMEOUT.
module uart_tx_arbiter
    import wfg_pkg::*;
#(
    parameter int         N_REQ    = 2,
    parameter int         MAX_LEN  = 16,
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ*8-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic               tx_done_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_wr_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_wr_q, tx_wr_d;
    logic             err_q, err_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    stall_q, stall_d;

    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    logic             sel_vld;
    logic [7:0]       sel_dat;
    logic             sel_last;
    logic [CW-1:0]    cnt_inc;
    logic             cap_hit;
    logic             stall_abort;

    rr_pick #(
        .N (N_REQ),
        .W (PW)
    ) u_pick (
        .req    (req_valid_i),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_vld     = |(req_valid_i & grant_q);
    assign sel_dat     = req_data_i[{idx_q, 3'b000} +: 8];
    assign sel_last    = req_last_i[idx_q];
    assign cnt_inc     = cnt_q + CW'(1);
    assign cap_hit     = (cnt_inc == CW'(MAX_LEN));
    assign stall_abort = (stall_q >= STALL_LIM);

    assign req_ready_o = (state_q == S_FETCH) ? grant_q : '0;
    assign tx_data_o   = tx_data_q;
    assign tx_wr_o     = tx_wr_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ptr_q     <= PW'(N_REQ - 1);
            idx_q     <= '0;
            busy_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            err_q     <= err_d;
            data_q    <= data_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_any) state_d = S_HDR;
            S_HDR:   state_d = S_WAIT;
            S_WAIT:  if (tx_done_i) state_d = last_q ? S_IDLE : S_FETCH;
            S_FETCH: begin
                if (sel_vld)          state_d = S_SEND;
                else if (stall_abort) state_d = S_IDLE;
            end
            S_SEND:  state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    ptr_d   = pick_idx;
                    idx_d   = pick_idx;
                    busy_d  = 1'b1;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    stall_d = '0;
                end
            end
            S_HDR: begin
                tx_data_d = hdr_byte(HDR_BASE, 3'(idx_q));
                tx_wr_d   = 1'b1;
            end
            S_WAIT: begin
                if (tx_done_i && last_q) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            S_FETCH: begin
                if (sel_vld) begin
                    // Hitting the length cap without last ends the frame after this byte
                    data_d  = sel_dat;
                    last_d  = sel_last | cap_hit;
                    err_d   = cap_hit & ~sel_last;
                    cnt_d   = cnt_inc;
                    stall_d = '0;
                end else if (stall_abort) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    stall_d = '0;
                end else begin
                    stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
                end
            end
            S_SEND: begin
                tx_data_d = data_q;
                tx_wr_d   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frame table, timeout/reset/spurious-done sequences,
// and randomized multi-frame traffic checked against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int ML = 4;
    localparam int TO = 12;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid_i;
    logic [N*8-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           tx_done_i;
    logic [7:0]     tx_data_o;
    logic           tx_wr_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           err_o;

    uart_tx_arbiter #(
        .N_REQ    (N),
        .MAX_LEN  (ML),
        .TIMEOUT  (TO),
        .HDR_BASE (8'hA0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_done_i   (tx_done_i),
        .tx_data_o   (tx_data_o),
        .tx_wr_o     (tx_wr_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]  b0;
        logic [7:0]   l0;
        logic [3:0]   n0;
        logic [63:0]  b1;
        logic [7:0]   l1;
        logic [3:0]   n1;
        logic [127:0] xs;
        logic [4:0]   nx;
        logic [1:0]   ne;
        logic [7:0]   dn;
    } vec_t;

    vec_t vt[5];

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] obs[$];
    logic [9:0] ex[$];
    int         ex_err;
    int         cd, dly, err_cnt, cyc, done_cyc, err_cyc;
    bit         auto_en, rnd_dly, spur;
    logic [7:0] hold_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One clock: sample outputs at negedge, model the UART, then drive requesters
    task automatic step();
        logic [7:0] d0, d1;
        logic       v0, v1, l0, l1;
        @(negedge clk);
        cyc++;
        if (!tx_wr_o && cd > 0) chk("tx_hold", {24'h0, tx_data_o}, {24'h0, hold_byte});
        if (err_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
        tx_done_i = spur;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                tx_done_i = 1'b1;
                done_cyc  = cyc;
            end
        end
        if (tx_wr_o) begin
            obs.push_back({grant_o, tx_data_o});
            hold_byte = tx_data_o;
            cd = rnd_dly ? int'($urandom_range(1, 6)) : dly;
        end
        if (auto_en) begin
            v0 = (q0.size() > 0);
            v1 = (q1.size() > 0);
            d0 = v0 ? q0[0][7:0] : 8'h00;
            d1 = v1 ? q1[0][7:0] : 8'h00;
            l0 = v0 ? q0[0][8] : 1'b0;
            l1 = v1 ? q1[0][8] : 1'b0;
            req_valid_i = {v1, v0};
            req_data_i  = {d1, d0};
            req_last_i  = {l1, l0};
            if (v0 && req_ready_o[0]) void'(q0.pop_front());
            if (v1 && req_ready_o[1]) void'(q1.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        auto_en     = 1'b0;
        spur        = 1'b0;
        rnd_dly     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_done_i   = 1'b0;
        q0.delete();
        q1.delete();
        obs.delete();
        cd      = 0;
        err_cnt = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_idle(input string name, input int budget);
        int idle;
        bit ok;
        idle = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && cd == 0 && !busy_o) idle++;
            else idle = 0;
            if (idle >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_done"}, {31'h0, ok}, 32'h1);
    endtask

    // Frame-level model: rotate from last owner, header, then bytes up to last or the cap
    task automatic build_model(input logic [8:0] m0_in[$], input logic [8:0] m1_in[$]);
        logic [8:0] m0[$];
        logic [8:0] m1[$];
        logic [8:0] b;
        logic [1:0] oh;
        int ptr, k;
        m0 = m0_in;
        m1 = m1_in;
        ptr = N - 1;
        ex.delete();
        ex_err = 0;
        while (m0.size() + m1.size() > 0) begin
            k = -1;
            for (int i = 1; i <= N; i++) begin
                if (k < 0 && ((((ptr + i) % N) == 0) ? m0.size() > 0 : m1.size() > 0))
                    k = (ptr + i) % N;
            end
            ptr = k;
            oh  = (k == 0) ? 2'b01 : 2'b10;
            ex.push_back({oh, 8'hA0 + 8'(k)});
            for (int j = 1; j <= ML; j++) begin
                b = (k == 0) ? m0.pop_front() : m1.pop_front();
                ex.push_back({oh, b[7:0]});
                if (b[8]) break;
                if (j == ML) ex_err++;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [8:0] r0[$];
        logic [8:0] r1[$];
        logic [7:0] rb;
        int len, to_done, base;

        vt[0] = '{b0: 64'h2211, l0: 8'b10, n0: 4'd2, b1: 64'h0, l1: 8'h0, n1: 4'd0,
                  xs: 128'h2211A0, nx: 5'd3, ne: 2'd0, dn: 8'd10};
        vt[1] = '{b0: 64'h0201, l0: 8'b11, n0: 4'd2, b1: 64'h8281, l1: 8'b11, n1: 4'd2,
                  xs: 128'h82A102A081A101A0, nx: 5'd8, ne: 2'd0, dn: 8'd3};
        vt[2] = '{b0: 64'h363534333231, l0: 8'b100000, n0: 4'd6, b1: 64'h0, l1: 8'h0, n1: 4'd0,
                  xs: 128'h3635A034333231A0, nx: 5'd8, ne: 2'd1, dn: 8'd3};
        vt[3] = '{b0: 64'h51, l0: 8'b1, n0: 4'd1, b1: 64'h44434241, l1: 8'b1000, n1: 4'd4,
                  xs: 128'h44434241A151A0, nx: 5'd7, ne: 2'd0, dn: 8'd3};
        vt[4] = '{b0: 64'h6564636261, l0: 8'b10000, n0: 4'd5, b1: 64'h71, l1: 8'b1, n1: 4'd1,
                  xs: 128'h65A071A164636261A0, nx: 5'd9, ne: 2'd1, dn: 8'd2};

        cyc = 0;
        dly = 3;
        rst_n = 1'b0;
        auto_en = 1'b0;
        spur = 1'b0;
        rnd_dly = 1'b0;
        cd = 0;
        err_cnt = 0;
        req_valid_i = '0;
        req_data_i = '0;
        req_last_i = '0;
        tx_done_i = 1'b0;
        step();
        chk("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        chk("rst_tx_wr", {31'h0, tx_wr_o}, 32'h0);
        chk("rst_grant", {30'h0, grant_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        chk("rst_ready", {30'h0, req_ready_o}, 32'h0);
        rst_n = 1'b1;
        step();

        // First tx_wr_o two cycles after the request is sampled
        req_valid_i = 2'b01;
        req_data_i  = 16'h0011;
        req_last_i  = 2'b01;
        step();
        chk("lat_grant", {30'h0, grant_o}, 32'h1);
        chk("lat_busy", {31'h0, busy_o}, 32'h1);
        chk("lat_wr_early", {31'h0, tx_wr_o}, 32'h0);
        step();
        chk("lat_wr", {31'h0, tx_wr_o}, 32'h1);
        chk("lat_hdr", {24'h0, tx_data_o}, 32'hA0);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            dly = int'(vt[t].dn);
            for (int j = 0; j < int'(vt[t].n0); j++) q0.push_back({vt[t].l0[j], vt[t].b0[8*j +: 8]});
            for (int j = 0; j < int'(vt[t].n1); j++) q1.push_back({vt[t].l1[j], vt[t].b1[8*j +: 8]});
            auto_en = 1'b1;
            run_idle($sformatf("tab%0d", t), 3000);
            chk($sformatf("tab%0d_len", t), obs.size(), {27'h0, vt[t].nx});
            for (int j = 0; j < int'(vt[t].nx); j++) begin
                chk($sformatf("tab%0d_byte%0d", t, j),
                    (j < obs.size()) ? {24'h0, obs[j][7:0]} : 32'hxxxxxxxx,
                    {24'h0, vt[t].xs[8*j +: 8]});
                if (t == 0 && j < obs.size())
                    chk($sformatf("tab0_grant%0d", j), {30'h0, obs[j][9:8]}, 32'h1);
            end
            chk($sformatf("tab%0d_err", t), err_cnt, {30'h0, vt[t].ne});
            chk($sformatf("tab%0d_grant_idle", t), {30'h0, grant_o}, 32'h0);
        end

        // Timeout: req1 sends one byte then stalls; spurious tx_done while fetching
        do_reset();
        dly = 3;
        auto_en = 1'b1;
        q1.push_back({1'b0, 8'h5A});
        for (int i = 0; i < 50 && grant_o != 2'b10; i++) step();
        chk("to_grant", {30'h0, grant_o}, 32'h2);
        q0.push_back({1'b1, 8'hC1});
        for (int i = 0; i < 100 && !(obs.size() == 2 && cd == 0 && req_ready_o[1]); i++) step();
        chk("to_fetch", {31'h0, req_ready_o[1]}, 32'h1);
        to_done = done_cyc;
        base = obs.size();
        spur = 1'b1;
        step();
        spur = 1'b0;
        run_idle("to", 500);
        chk("to_err_cnt", err_cnt, 1);
        chk("to_err_cycle", err_cyc - to_done, TO + 1);
        chk("to_len", obs.size(), base + 2);
        if (obs.size() >= 4) begin
            chk("to_b0", {22'h0, obs[0]}, {22'h0, 2'b10, 8'hA1});
            chk("to_b1", {22'h0, obs[1]}, {22'h0, 2'b10, 8'h5A});
            chk("to_b2", {22'h0, obs[2]}, {22'h0, 2'b01, 8'hA0});
            chk("to_b3", {22'h0, obs[3]}, {22'h0, 2'b01, 8'hC1});
        end

        // Reset asserted mid-frame while waiting on tx_done
        do_reset();
        dly = 10;
        auto_en = 1'b1;
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b1, 8'h22});
        for (int i = 0; i < 50 && obs.size() == 0; i++) step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_tx_data", {24'h0, tx_data_o}, 32'h0);
        chk("mrst_tx_wr", {31'h0, tx_wr_o}, 32'h0);
        chk("mrst_grant", {30'h0, grant_o}, 32'h0);
        chk("mrst_busy", {31'h0, busy_o}, 32'h0);
        chk("mrst_err", {31'h0, err_o}, 32'h0);
        do_reset();
        dly = 3;
        auto_en = 1'b1;
        q1.push_back({1'b1, 8'h33});
        run_idle("mrst", 500);
        chk("mrst_len", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("mrst_hdr", {24'h0, obs[0][7:0]}, 32'hA1);
            chk("mrst_pay", {24'h0, obs[1][7:0]}, 32'h33);
        end

        // Spurious tx_done while idle
        base = obs.size();
        spur = 1'b1;
        step();
        step();
        step();
        spur = 1'b0;
        step();
        chk("spur_idle_wr", obs.size(), base);
        chk("spur_idle_busy", {31'h0, busy_o}, 32'h0);

        // Randomized multi-frame traffic against the frame-level model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            rnd_dly = 1'b1;
            r0.delete();
            r1.delete();
            for (int k = 0; k < N; k++) begin
                for (int f = 0; f < 4; f++) begin
                    len = int'($urandom_range(1, 6));
                    for (int j = 0; j < len; j++) begin
                        rb = 8'($urandom_range(0, 255));
                        if (k == 0) r0.push_back({j == len - 1, rb});
                        else        r1.push_back({j == len - 1, rb});
                    end
                end
            end
            build_model(r0, r1);
            q0 = r0;
            q1 = r1;
            auto_en = 1'b1;
            run_idle($sformatf("rnd%0d", r), 5000);
            chk($sformatf("rnd%0d_len", r), obs.size(), ex.size());
            for (int j = 0; j < ex.size(); j++)
                chk($sformatf("rnd%0d_b%0d", r, j),
                    (j < obs.size()) ? {22'h0, obs[j]} : 32'hxxxxxxxx, {22'h0, ex[j]});
            chk($sformatf("rnd%0d_err", r), err_cnt, ex_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
